// File: rtl/serial_word_deser_pkg.sv
// Shared types and helpers for the serial-to-parallel word deserializer.
// The parity state is only used when SERIAL_WORD_DESER_PARITY_EN is defined.
package serial_word_deser_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } deser_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_deser_out_buf.sv
// One-entry valid/ready holding register for assembled words.
// A load that arrives while the held word is still unconsumed is dropped and reported on drop.
module deser_out_buf #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          drop
);

    logic          valid_reg;
    logic [DW-1:0] data_reg;
    logic          accept;

    // A completing handshake frees the slot in the same cycle, so a load can replace it.
    assign accept = load && (!valid_reg || ready);
    assign drop   = load && valid_reg && !ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (accept) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (valid_reg && ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/serial_word_deser.sv
// Serial bit stream to WIDTH-bit word assembler with a one-entry output buffer and sticky overflow.
// Define SERIAL_WORD_DESER_PARITY_EN to expect an even-parity bit after every word.
module serial_word_deser
    import serial_word_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bit_in,
    input  logic                        bit_valid,
    input  logic                        clear,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overflow,
    output logic                        parity_err,
    output logic [cnt_width(WIDTH)-1:0] bit_cnt
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    cnt_reg;
    logic             overflow_reg;
    logic             load;
    logic [WIDTH:0]   load_word;
    logic [WIDTH:0]   buf_word;
    logic             buf_drop;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign shift_next[gi] = bit_in;
                end else begin : g_mv
                    assign shift_next[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_in
                    assign shift_next[gi] = bit_in;
                end else begin : g_mv
                    assign shift_next[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

`ifdef SERIAL_WORD_DESER_PARITY_EN
    deser_state_t state_reg;

    // The word is already complete in shift_reg; the bit arriving now is its parity bit.
    assign load      = bit_valid && (state_reg == PARITY);
    assign load_word = {^{shift_reg, bit_in}, shift_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= COLLECT;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (clear) begin
            state_reg <= COLLECT;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (bit_valid) begin
            if (state_reg == COLLECT) begin
                shift_reg <= shift_next;
                if (cnt_reg == LAST_CNT) begin
                    state_reg <= PARITY;
                    cnt_reg   <= CW'(WIDTH);
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                state_reg <= COLLECT;
                cnt_reg   <= '0;
            end
        end
    end
`else
    // The last data bit is taken straight from shift_next so the word loads on its own edge.
    assign load      = bit_valid && (cnt_reg == LAST_CNT);
    assign load_word = {1'b0, shift_next};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (bit_valid) begin
            shift_reg <= shift_next;
            cnt_reg   <= (cnt_reg == LAST_CNT) ? '0 : cnt_reg + 1'b1;
        end
    end
`endif

    deser_out_buf #(
        .DW(WIDTH + 1)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (load),
        .load_data (load_word),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (buf_word),
        .drop      (buf_drop)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_reg <= 1'b0;
        end else if (clear) begin
            overflow_reg <= 1'b0;
        end else if (buf_drop) begin
            overflow_reg <= 1'b1;
        end
    end

    // Without parity the stored top bit is always loaded as 0.
    assign parity_err = buf_word[WIDTH];
    assign out_data   = buf_word[WIDTH-1:0];
    assign overflow   = overflow_reg;
    assign bit_cnt    = cnt_reg;

endmodule

// File: doc/serial_word_deser.md
Name: serial_word_deser

Overview:
- Downstream stage of the registered 2:1 select flop: consumes its 1-bit registered output `q` as a serial bit stream.
- Assembles WIDTH bits into a parallel word.
- Presents each word on a one-entry valid/ready output buffer.
- Flags words lost to backpressure.

Parameters:
- WIDTH, 8, data bits per word (≥2).
- MSB_FIRST, 1, 1 = first received bit lands in out_data[WIDTH-1]; 0 = first bit lands in out_data[0].

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- bit_in  in  1  serial bit (the upstream flop's q).
- bit_valid  in  1  bit_in is sampled on posedge clk when 1.
- clear  in  1  synchronous flush.
- out_data  out  WIDTH  assembled word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- overflow  out  1  sticky; at least one word was dropped.
- parity_err  out  1  parity status of out_data (see Optional Feature).
- bit_cnt  out  $clog2(WIDTH+1)  data bits collected in the current word.

Behaviour:
- Reset (rst=0, async):
  - All outputs and internal state go to 0; state=COLLECT.
  - Reset mid-word discards the partial word, with no output.
- clear=1:
  - On the next posedge, same effect as reset.
  - Highest priority over all other events in that cycle.
- States: COLLECT, PARITY (PARITY exists only with the macro).
- COLLECT:
  - Each bit_valid cycle shifts bit_in into the shift register and increments bit_cnt.
  - bit_valid=0 cycles hold all state; gaps of any length are legal.
- Word completion (WIDTH-th bit sampled):
  - Without the macro, the word is loaded into the output buffer at the same posedge.
  - out_valid=1 and out_data is visible the cycle after the last bit's posedge; latency is 1 cycle from the last bit.
  - bit_cnt returns to 0.
- Output handshake:
  - out_valid drops on the posedge where out_valid && out_ready, unless a new word completes in that same cycle.
  - Completion plus handshake in the same cycle: the new word is loaded and out_valid stays 1; no overflow.
  - Completion while out_valid=1 and out_ready=0: the new word is dropped, the buffer keeps the old word, overflow←1, and bit_cnt restarts at 0.
- overflow is cleared only by rst or clear.
- out_data is stable while out_valid && !out_ready.
- Bit ordering:
  - MSB_FIRST=1: shift left, new bit into bit 0.
  - MSB_FIRST=0: shift right, new bit into bit WIDTH-1.

Optional Feature:
- Macro: SERIAL_WORD_DESER_PARITY_EN.
- Defined:
  - After the WIDTH-th data bit, state→PARITY.
  - The next bit_valid bit is the even-parity bit; bit_cnt holds WIDTH during PARITY.
  - On that bit, the word loads to the output with parity_err = ^{data, parity_bit}, then state→COLLECT and bit_cnt=0.
  - Overflow and handshake rules apply at this load cycle instead of at the WIDTH-th bit.
  - parity_err is valid with out_valid and holds with out_data.
- Undefined: PARITY state absent; parity_err tied 0; the port remains present.

Decomposition:
- Package serial_word_deser_pkg:
  - state enum typedef deser_state_t {COLLECT, PARITY}.
  - Function cnt_width(WIDTH) returning $clog2(WIDTH+1).
- Sub-module deser_out_buf:
  - One-entry valid/ready holding register, WIDTH+1 bits (data + parity_err).
  - Inputs: load, data; outputs: valid, drop pulse used for overflow.
- Top module holds the shift register, counter and FSM.

Test Plan:
- WIDTH=8, MSB_FIRST=1, out_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles → out_data=8'hA5, out_valid=1 for 1 cycle, exactly 1 cycle after the 8th bit.
- MSB_FIRST=0, same bits with 0–3 idle cycles inserted randomly between bits → out_data=8'hA5 (bit-reversed packing of the same stream), bit_cnt tracks 0..7 and holds during gaps.
- out_ready=0, send two words 8'h3C then 8'hF0 → out_data stays 8'h3C, overflow=1; then out_ready=1 → handshake, out_valid=0, overflow stays 1 until clear.
- out_ready=1 asserted in exactly the cycle the second word completes → out_data switches 8'h3C→8'hF0, out_valid never drops, overflow=0.
- Assert rst=0 after 5 bits, release, send 8 bits of 8'h81 → out_data=8'h81; no spurious word from the partial 5 bits.
- Macro defined: send 8'hA5 + parity 0 → parity_err=0; send 8'hA5 + parity 1 → parity_err=1; bit_cnt=8 during the PARITY wait.
